// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared geometry and row types for the 8x8 LED matrix datapath
package led_matrix_pkg;
  localparam int LED_ROWS = 8;
  localparam int LED_COLS = 8;
  typedef logic [2:0] row_idx_t;
  typedef logic [LED_COLS-1:0] row_data_t;
endpackage

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: two 8x8 frames; writes land in the back frame, reads come from the front
module led_frame_buffer
  import led_matrix_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      wr_en,
  input  row_idx_t  wr_row,
  input  row_data_t wr_data,
  input  logic      swap,
  input  row_idx_t  rd_row,
  output row_data_t rd_data
);
  row_data_t mem [2][LED_ROWS];
  logic front;
  // a write on the swap edge still targets the pre-swap back frame
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      front <= 1'b0;
      for (int r = 0; r < LED_ROWS; r++) begin
        mem[0][r] <= '0;
        mem[1][r] <= '0;
      end
    end else begin
      if (wr_en) mem[~front][wr_row] <= wr_data;
      if (swap) front <= ~front;
    end
  assign rd_data = mem[front][rd_row];
endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed refresh of a double-buffered 8x8 frame with anti-ghost blanking
// LED_MATRIX_SCAN_DIM_EN adds a brightness input that gates cols to a 1/16-step duty per dwell.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int clk_div_width = 16,
  parameter int blank_cycles  = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      wr_en,
  input  row_idx_t  wr_row,
  input  row_data_t wr_data,
  input  logic      swap_req,
`ifdef LED_MATRIX_SCAN_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic      swap_ack,
  output logic      frame_start,
  output row_data_t rows,
  output row_data_t cols
);
  localparam logic [clk_div_width-1:0] blank_lim = clk_div_width'(blank_cycles);
  logic [clk_div_width-1:0] cnt;
  row_idx_t  row_idx;
  row_data_t front_row;
  logic tc, boundary, swap, blank, dark;
  assign tc       = &cnt;
  assign boundary = tc && row_idx == 3'd7;
  assign swap     = boundary && swap_req;
  assign blank    = cnt < blank_lim;
`ifdef LED_MATRIX_SCAN_DIM_EN
  logic [3:0] bright_q;
  // latched on the edge that starts each dwell so the duty is stable within a row
  always_ff @(posedge clock or posedge reset)
    if (reset) bright_q <= '0;
    else if (tc) bright_q <= brightness;
  assign dark = cnt[clk_div_width-1 -: 4] >= bright_q;
`else
  assign dark = 1'b0;
`endif
  led_frame_buffer u_frame (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .swap    (swap),
    .rd_row  (row_idx),
    .rd_data (front_row)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt         <= '0;
      row_idx     <= '0;
      rows        <= '0;
      cols        <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt + clk_div_width'(1);
      row_idx     <= tc ? row_idx + 3'd1 : row_idx;
      rows        <= blank ? '0 : row_data_t'(1) << row_idx;
      cols        <= (blank || dark) ? '0 : front_row;
      swap_ack    <= swap;
      frame_start <= boundary;
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: randomized scan/swap stimulus checked against a cycle-count frame model
module tb_led_matrix_scan;
`ifdef LED_MATRIX_SCAN_DIM_EN
  localparam bit dim_en = 1'b1;
`else
  localparam bit dim_en = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, wr_en = 1'b0, swap_req = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] brightness = 4'd15;
  logic swap_ack, frame_start;
  logic [7:0] rows, cols;
  int checks = 0, errors = 0;
  logic [7:0] m_mem [2][8];
  int m_front, cyc;
  logic [3:0] m_bright;
  logic [17:0] exp_v;

  always #5 clock = ~clock;

  led_matrix_scan #(.clk_div_width(4), .blank_cycles(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
`ifdef LED_MATRIX_SCAN_DIM_EN
    .brightness  (brightness),
`endif
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .rows        (rows),
    .cols        (cols)
  );

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) m_mem[b][r] = 8'h00;
    m_front = 0;
    cyc = 0;
    m_bright = 4'd0;
  endtask

  // Frame model: cycle c since reset is dwell phase c%16 of row (c/16)%8; a frame is 128 cycles.
  task automatic tick();
    int c, ph, row;
    logic [7:0] r, cl;
    logic ack, fs;
    @(posedge clock);
    c = cyc; ph = c % 16; row = (c / 16) % 8;
    r  = (ph < 4) ? 8'h00 : 8'h01 << row;
    cl = (ph < 4) ? 8'h00 : m_mem[m_front][row];
    if (dim_en && ph >= int'(m_bright)) cl = 8'h00;
    if (ph == 15) m_bright = brightness;
    fs = (c % 128 == 127);
    ack = fs && swap_req;
    if (wr_en) m_mem[1 - m_front][wr_row] = wr_data;
    if (ack) m_front = 1 - m_front;
    exp_v = {r, cl, ack, fs};
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int fs_n = 0, ack_n = 0;
    checks++; if ({rows, cols, swap_ack, frame_start} !== 18'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", {rows, cols, swap_ack, frame_start}); end
    for (int i = 0; i < 384; i++) begin
      tick();
      fs_n += int'(frame_start); ack_n += int'(swap_ack);
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL idle_scan cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    checks++; if (fs_n != 3) begin errors++; $display("FAIL idle_frame_starts got %0d want 3", fs_n); end
    checks++; if (ack_n != 0) begin errors++; $display("FAIL idle_swap_acks got %0d want 0", ack_n); end
  endtask

  task automatic test_diagonal();
    int lit = 0, dark_n = 0;
    bit got = 0;
    int lit_per = dim_en ? 11 : 12;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_row = 3'(k); wr_data = 8'h01 << k;
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL diag_write cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    wr_en = 0; swap_req = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL diag_swap cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
      if (swap_ack) begin got = 1; swap_req = 0; end
    end
    swap_req = 0;
    checks++; if (!got) begin errors++; $display("FAIL diag_swap_ack got none want pulse"); end
    for (int i = 0; i < 128; i++) begin
      tick();
      if (rows != 0 && cols == rows) lit++;
      if (rows == 0 && cols == 0) dark_n++;
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL diag_frame cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    checks++; if (lit != 8 * lit_per) begin errors++; $display("FAIL diag_lit got %0d want %0d", lit, 8 * lit_per); end
    checks++; if (dark_n != 32) begin errors++; $display("FAIL diag_blank got %0d want 32", dark_n); end
  endtask

  task automatic test_no_swap();
    bit got = 0;
    int n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_row = 3'((3 + $urandom_range(1, 7)) % 8); wr_data = 8'($urandom);
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL ns_write cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    wr_row = 3'd3; wr_data = 8'hA5;
    tick();
    wr_en = 0;
    for (int i = 0; i < 384; i++) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL ns_hold cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
      if ((cyc - 1) % 16 == 8) begin
        checks++; if (cols !== 8'h01 << ((cyc - 1) / 16 % 8)) begin errors++; $display("FAIL ns_unchanged cyc %0d got %h", cyc, cols); end
      end
    end
    swap_req = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL ns_swap cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
      if (swap_ack) begin got = 1; swap_req = 0; end
    end
    swap_req = 0;
    checks++; if (!got) begin errors++; $display("FAIL ns_swap_ack got none want pulse"); end
    for (int i = 0; i < 128; i++) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL ns_frame cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
      if ((cyc - 1) % 128 == 3 * 16 + 8) begin
        checks++; if (cols !== 8'hA5) begin errors++; $display("FAIL ns_row3 got %h want a5", cols); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int r = $urandom_range(0, 7);
    int q = (r + 3) % 8;
    logic [7:0] last = 8'h00, qd = 8'($urandom) | 8'h01;
    while (cyc % 128 != 0) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL b2b_align cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_row = 3'(r); wr_data = 8'($urandom); last = wr_data;
      tick();
    end
    wr_en = 0;
    while (cyc % 128 != 127) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL b2b_wait cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    wr_en = 1; wr_row = 3'(q); wr_data = qd; swap_req = 1;
    tick();
    wr_en = 0; swap_req = 0;
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("FAIL b2b_swap_ack got %b want 1", swap_ack); end
    for (int i = 0; i < 128; i++) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL b2b_frame cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
      if ((cyc - 1) % 128 == r * 16 + 8) begin
        checks++; if (cols !== last) begin errors++; $display("FAIL b2b_last_wins got %h want %h", cols, last); end
      end
      if ((cyc - 1) % 128 == q * 16 + 8) begin
        checks++; if (cols !== qd) begin errors++; $display("FAIL b2b_swap_edge_write got %h want %h", cols, qd); end
      end
    end
  endtask

  task automatic test_hold_swap();
    int acks = 0;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_row = 3'(k); wr_data = 8'($urandom);
      tick();
    end
    wr_en = 0;
    while (cyc % 128 != 0) tick();
    swap_req = 1;
    for (int i = 0; i < 384; i++) begin
      wr_en = ($urandom_range(0, 3) == 0); wr_row = 3'($urandom); wr_data = 8'($urandom);
      tick();
      acks += int'(swap_ack);
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL hold_swap cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    swap_req = 0; wr_en = 0;
    checks++; if (acks != 3) begin errors++; $display("FAIL hold_swap_acks got %0d want 3", acks); end
  endtask

`ifdef LED_MATRIX_SCAN_DIM_EN
  task automatic test_dim();
    int lit = 0;
    bit got = 0;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_row = 3'(k); wr_data = 8'hFF;
      tick();
    end
    wr_en = 0; brightness = 4'd8; swap_req = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (swap_ack) begin got = 1; swap_req = 0; end
    end
    swap_req = 0;
    checks++; if (!got) begin errors++; $display("FAIL dim_swap_ack got none want pulse"); end
    for (int i = 0; i < 128; i++) begin
      tick();
      if (cols != 0) lit++;
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL dim_8 cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    checks++; if (lit != 32) begin errors++; $display("FAIL dim_8_lit got %0d want 32", lit); end
    brightness = 4'd0; lit = 0;
    repeat (16) tick();
    for (int i = 0; i < 128; i++) begin
      tick();
      if (cols != 0) lit++;
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL dim_0 cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL dim_0_lit got %0d want 0", lit); end
    brightness = 4'd15;
    repeat (16) tick();
  endtask
`endif

  task automatic test_mid_reset();
    int lit = 0;
    bit got = 0;
    while (cyc % 128 != 5 * 16 + 8) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL mr_pre cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
    end
    checks++; if (rows !== 8'h20) begin errors++; $display("FAIL mr_row5 got %h want 20", rows); end
    wr_en = 1; wr_row = 3'd5; wr_data = 8'hFF; swap_req = 1;
    #2 reset = 1;
    #1;
    checks++; if ({rows, cols, swap_ack, frame_start} !== 18'h0) begin errors++; $display("FAIL mr_async got %h want 0", {rows, cols, swap_ack, frame_start}); end
    wr_en = 0; swap_req = 0;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    swap_req = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      checks++; if ({rows, cols, swap_ack, frame_start} !== exp_v) begin errors++; $display("FAIL mr_restart cyc %0d got %h want %h", cyc, {rows, cols, swap_ack, frame_start}, exp_v); end
      if (i == 4) begin
        checks++; if (rows !== 8'h01) begin errors++; $display("FAIL mr_row0_first got %h want 01", rows); end
      end
      if (swap_ack) begin got = 1; swap_req = 0; end
    end
    swap_req = 0;
    checks++; if (!got) begin errors++; $display("FAIL mr_swap_ack got none want pulse"); end
    for (int i = 0; i < 128; i++) begin
      tick();
      if (cols != 0) lit++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL mr_cleared got %0d lit want 0", lit); end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clock);
    reset = 0;
    test_reset();
    test_diagonal();
    test_no_swap();
    test_back_to_back();
    test_hold_swap();
`ifdef LED_MATRIX_SCAN_DIM_EN
    test_dim();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
